exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 27 ++
 rtl/exec_unit_if.sv | 39 +++
 rtl/exec_unit_seq_mult.sv | 57 +++++
 rtl/exec_unit.sv | 125 ++++++++++++
 tb/tb_exec_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: shared definitions for the execution unit.
//   - opcode encodings (3-bit)
//   - FSM state encoding (IDLE, READ, EXEC, WB)
//   - widths of the opcode, immediate and multiplier iteration counter
package exec_unit_pkg;

  localparam int OPC_W     = 3;
  localparam int IMM_W     = 8;
  localparam int MUL_CNT_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDI = 3'b101;
  localparam logic [OPC_W-1:0] OP_MUL = 3'b110;
  localparam logic [OPC_W-1:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/exec_unit_if.sv
// exec_unit_if: instruction handshake plus register-file read/write ports.
//   instr_valid/instr_ready, opcode, rd, rs1, rs2, imm : instruction bus
//   r_add1/r_add2 -> r_data1/r_data2                  : combinational reads
//   w_add, w_flag, w_data                              : synchronous write
//   busy, done                                         : unit status
// slave  = the execution unit, master = the environment (issuer + register file).
interface exec_unit_if
  import exec_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] r_add1;
  logic [ADDR_W-1:0] r_add2;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [ADDR_W-1:0] w_add;
  logic              w_flag;
  logic [DATA_W-1:0] w_data;
  logic              busy;
  logic              done;

  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, imm, r_data1, r_data2,
    output instr_ready, r_add1, r_add2, w_add, w_flag, w_data, busy, done
  );

  modport master (
    output instr_valid, opcode, rd, rs1, rs2, imm, r_data1, r_data2,
    input  instr_ready, r_add1, r_add2, w_add, w_flag, w_data, busy, done
  );
endinterface

// File: rtl/exec_unit_seq_mult.sv
// seq_mult: shift-add multiplier, one multiplier bit per cycle.
//   start   : load operands a/b (one-cycle pulse)
//   a, b    : multiplicand / multiplier
//   done    : high during the last of DATA_W iteration cycles
//   product : low DATA_W bits of a*b, valid while done is high
module seq_mult
  import exec_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  logic [DATA_W-1:0]    acc;
  logic [DATA_W-1:0]    mcand;
  logic [DATA_W-1:0]    mplier;
  logic [MUL_CNT_W-1:0] cnt;
  logic                 running;
  logic [DATA_W-1:0]    acc_nxt;

  // The product is exposed combinationally so the final partial sum is
  // usable in the same cycle done is raised; high bits shift out (wrap).
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  assign done    = running && (cnt == MUL_CNT_W'(DATA_W - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + MUL_CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execution unit, IDLE -> READ -> EXEC -> WB.
//   clk, reset : clock and synchronous active-high reset
//   bus        : exec_unit_if.slave (instruction handshake, register-file
//                read/write ports, busy/done status)
// ALU ops take one EXEC cycle; MUL spends DATA_W EXEC cycles in seq_mult.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  exec_unit_if.slave   bus
);
  state_t            state, state_nxt;
  logic [OPC_W-1:0]  op_p0;
  logic [ADDR_W-1:0] rd_p0;
  logic [IMM_W-1:0]  imm_p0;
  logic [ADDR_W-1:0] radd1, radd2;
  logic [DATA_W-1:0] opa_p1, opb_p1;
  logic [DATA_W-1:0] result_p2;
  logic              accept;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              busy, done, w_flag;

  function automatic logic [DATA_W-1:0] alu(input logic [OPC_W-1:0]  op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [IMM_W-1:0]  imm);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_LDI:  alu = DATA_W'(imm);
      OP_SHL:  alu = a << b[3:0];
      default: alu = '0;
    endcase
  endfunction

  assign bus.instr_ready = (state == ST_IDLE) && !reset;
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign mul_start       = (state == ST_READ) && (op_p0 == OP_MUL);

  seq_mult #(.DATA_W(DATA_W)) u_mult (
    .clk     (clk),
    .rst     (reset),
    .start   (mul_start),
    .a       (bus.r_data1),
    .b       (bus.r_data2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    w_flag    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: if (op_p0 != OP_MUL || mul_done) state_nxt = ST_WB;
      ST_WB: begin
        done      = 1'b1;
        w_flag    = (op_p0 != OP_NOP);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_p0     <= '0;
      rd_p0     <= '0;
      imm_p0    <= '0;
      radd1     <= '0;
      radd2     <= '0;
      opa_p1    <= '0;
      opb_p1    <= '0;
      result_p2 <= '0;
    end else begin
      // p0: instruction latch; read addresses move only on accept and hold otherwise
      if (accept) begin
        op_p0  <= bus.opcode;
        rd_p0  <= bus.rd;
        imm_p0 <= bus.imm;
        radd1  <= bus.rs1;
        radd2  <= bus.rs2;
      end
      // p1: operand capture at end of READ (pre-write values even if rd aliases rs)
      if (state == ST_READ) begin
        opa_p1 <= bus.r_data1;
        opb_p1 <= bus.r_data2;
      end
      // p2: result register
      if (state == ST_EXEC) begin
        if (op_p0 == OP_MUL) begin
          if (mul_done) result_p2 <= mul_product;
        end else begin
          result_p2 <= alu(op_p0, opa_p1, opb_p1, imm_p0);
        end
      end
    end
  end

  assign bus.r_add1 = radd1;
  assign bus.r_add2 = radd2;
  assign bus.w_add  = rd_p0;
  assign bus.w_data = result_p2;
  assign bus.w_flag = w_flag;
  assign bus.busy   = busy;
  assign bus.done   = done;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: bench for exec_unit with an attached 4x16 register file,
// a transaction-level reference model and directed plus random stimulus.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rf_rst = 1'b1;
  always #5 clk = ~clk;

  exec_unit_if #(.DATA_W(16), .ADDR_W(2)) bus();
  exec_unit #(.DATA_W(16), .ADDR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: synchronous write/reset, combinational reads.
  logic        pre_we = 1'b0;
  logic [1:0]  pre_addr = 2'd0;
  logic [15:0] pre_data = 16'd0;
  logic [15:0] rf [4];

  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 16'd0;
    end else begin
      if (bus.w_flag) rf[bus.w_add] <= bus.w_data;
      if (pre_we) rf[pre_addr] <= pre_data;
    end
  end
  assign bus.r_data1 = rf[bus.r_add1];
  assign bus.r_data2 = rf[bus.r_add2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding instruction, countdown to its WB cycle.
  logic [15:0] mreg [4];
  bit          m_pending = 1'b0;
  int          m_rem = 0;
  logic [2:0]  m_op = 3'd0;
  logic [1:0]  m_rd = 2'd0;
  logic [1:0]  m_radd1 = 2'd0;
  logic [1:0]  m_radd2 = 2'd0;
  logic [15:0] m_res = 16'd0;
  bit          m_clean = 1'b1;

  function automatic logic [15:0] model_res(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [7:0] imm);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned sh = b % 16;
    case (op)
      3'd1: return 16'((ua + ub) % 65536);
      3'd2: return 16'((ua + 65536 - ub) % 65536);
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return {8'h00, imm};
      3'd6: return 16'((ua * ub) % 65536);
      3'd7: return 16'((ua << sh) % 65536);
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_step();
    bit wf = m_pending && (m_rem == 0) && (m_op != 3'd0);
    if (rf_rst) begin
      for (int i = 0; i < 4; i++) mreg[i] = 16'd0;
    end else begin
      if (wf) mreg[m_rd] = m_res;
      if (pre_we) mreg[pre_addr] = pre_data;
    end
    if (reset) begin
      m_pending = 1'b0;
      m_radd1 = 2'd0;
      m_radd2 = 2'd0;
      m_rd = 2'd0;
      m_res = 16'd0;
      m_clean = 1'b1;
    end else if (m_pending) begin
      if (m_rem == 0) m_pending = 1'b0;
      else m_rem--;
    end else if (bus.instr_valid === 1'b1) begin
      m_pending = 1'b1;
      m_op = bus.opcode;
      m_rd = bus.rd;
      m_radd1 = bus.rs1;
      m_radd2 = bus.rs2;
      m_res = model_res(bus.opcode, mreg[bus.rs1], mreg[bus.rs2], bus.imm);
      m_rem = ((bus.opcode == 3'd6) ? 18 : 3) - 1;
      m_clean = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  task automatic compare();
    bit ed = m_pending && (m_rem == 0);
    bit ew = ed && (m_op != 3'd0);
    chk("instr_ready", bus.instr_ready, !m_pending && !reset);
    chk("busy", bus.busy, m_pending);
    chk("done", bus.done, ed);
    chk("w_flag", bus.w_flag, ew);
    chk("r_add1", bus.r_add1, m_radd1);
    chk("r_add2", bus.r_add2, m_radd2);
    if (ew) begin
      chk("w_add", bus.w_add, m_rd);
      chk("w_data", bus.w_data, m_res);
    end
    if (m_clean && !m_pending) begin
      chk("w_add_rst", bus.w_add, 2'd0);
      chk("w_data_rst", bus.w_data, 16'd0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  task automatic preload(input logic [1:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #2;
    pre_we = 1'b0;
  endtask

  // Holds the instruction valid until accepted; returns two time units after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, output int acc);
    acc = -1;
    bus.instr_valid = 1'b1; bus.opcode = op; bus.rd = rd;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1) begin
        acc = cyc;
        @(posedge clk); #2;
        bus.instr_valid = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    bus.instr_valid = 1'b0;
    n_checks++; n_fail++;
    $display("FAIL accept_timeout: instruction not accepted within 60 cycles, required acceptance");
  endtask

  task automatic wait_done(input int acc, output int lat, output logic wf,
                           output logic [1:0] wa, output logic [15:0] wd);
    lat = -1; wf = 1'b0; wa = 2'd0; wd = 16'd0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc - acc; wf = bus.w_flag; wa = bus.w_add; wd = bus.w_data;
        @(posedge clk); #2;
        return;
      end
      @(posedge clk); #2;
    end
    n_checks++; n_fail++;
    $display("FAIL done_timeout: no done pulse within 60 cycles, required one");
  endtask

  initial begin
    int acc, acc2, lat;
    logic wf;
    logic [1:0] wa;
    logic [15:0] wd;

    bus.instr_valid = 1'b0; bus.opcode = 3'd0; bus.rd = 2'd0;
    bus.rs1 = 2'd0; bus.rs2 = 2'd0; bus.imm = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_w_flag", bus.w_flag, 1'b0);
    chk("rst_r_add1", bus.r_add1, 2'd0);
    chk("rst_r_add2", bus.r_add2, 2'd0);
    chk("rst_w_add", bus.w_add, 2'd0);
    chk("rst_w_data", bus.w_data, 16'd0);
    @(posedge clk); #2;
    reset = 1'b0; rf_rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.instr_ready, 1'b1);
    @(posedge clk); #2;

    // LDI rd=1 imm=0xAB
    issue(3'b101, 2'd1, 2'd0, 2'd0, 8'hAB, acc);
    wait_done(acc, lat, wf, wa, wd);
    chk("ldi_latency", lat, 3);
    chk("ldi_w_flag", wf, 1'b1);
    chk("ldi_w_add", wa, 2'd1);
    chk("ldi_w_data", wd, 16'h00AB);
    chk("ldi_r1", rf[1], 16'h00AB);

    // ADD wrap and SUB
    preload(2'd0, 16'hFFFF);
    preload(2'd1, 16'h0002);
    issue(3'b001, 2'd2, 2'd0, 2'd1, 8'd0, acc);
    wait_done(acc, lat, wf, wa, wd);
    chk("add_wrap_r2", rf[2], 16'h0001);
    issue(3'b010, 2'd3, 2'd1, 2'd0, 8'd0, acc);
    wait_done(acc, lat, wf, wa, wd);
    chk("sub_r3", rf[3], 16'h0003);

    // MUL with an ignored instruction offered while busy
    preload(2'd1, 16'h0123);
    preload(2'd2, 16'h0010);
    issue(3'b110, 2'd3, 2'd1, 2'd2, 8'd0, acc);
    bus.instr_valid = 1'b1; bus.opcode = 3'b101; bus.rd = 2'd0; bus.imm = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mul_ready_low", bus.instr_ready, 1'b0);
      @(posedge clk); #2;
    end
    bus.instr_valid = 1'b0;
    wait_done(acc, lat, wf, wa, wd);
    chk("mul_latency", lat, 18);
    chk("mul_w_data", wd, 16'h1230);
    chk("mul_r3", rf[3], 16'h1230);
    chk("mul_ignored_r0", rf[0], 16'hFFFF);

    // Self-referencing ADD and back-to-back accepts
    preload(2'd1, 16'h4000);
    issue(3'b001, 2'd1, 2'd1, 2'd1, 8'd0, acc);
    issue(3'b101, 2'd2, 2'd0, 2'd0, 8'h11, acc2);
    chk("b2b_spacing", acc2 - acc, 4);
    wait_done(acc2, lat, wf, wa, wd);
    chk("b2b_latency", lat, 3);
    chk("self_add_r1", rf[1], 16'h8000);
    chk("b2b_ldi_r2", rf[2], 16'h0011);

    // Reset in the middle of a MUL
    preload(2'd3, 16'h7777);
    issue(3'b110, 2'd3, 2'd1, 2'd1, 8'd0, acc);
    repeat (7) begin @(posedge clk); #2; end
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.instr_ready, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_w_flag", bus.w_flag, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_r_add1", bus.r_add1, 2'd0);
    chk("midrst_w_add", bus.w_add, 2'd0);
    chk("midrst_w_data", bus.w_data, 16'd0);
    repeat (20) begin @(posedge clk); #2; end
    chk("midrst_no_write", rf[3], 16'h7777);

    // NOP: done pulse without a write
    issue(3'b000, 2'd2, 2'd1, 2'd3, 8'd0, acc);
    wait_done(acc, lat, wf, wa, wd);
    chk("nop_latency", lat, 3);
    chk("nop_w_flag", wf, 1'b0);
    chk("nop_r2_kept", rf[2], 16'h0011);

    // Random instruction stream
    for (int i = 0; i < 4; i++) preload(2'(i), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
            8'($urandom), acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    repeat (25) begin @(posedge clk); #2; end
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("final_regfile", rf[i], mreg[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
